// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq
// Sequential 64-bit unsigned multiply / divide engine that borrows a shared,
// external 64-bit ALU. A multiply is shift-and-add over 64 cycles and keeps
// the low 64 bits of the product. A divide is restoring division over 64
// cycles and returns the quotient and remainder. A divide by zero skips the
// iterations and completes with result=0, remainder=dividend and
// div_by_zero=1.
//
// Ports
//   clk          in   single clock, rising edge
//   reset        in   asynchronous, active-high
//   start        in   request pulse, sampled only while idle
//   op           in   0 = multiply (low 64 bits), 1 = divide
//   opA / opB    in   multiplicand / multiplier, or dividend / divisor
//   busy         out  operation in progress
//   done         out  one-cycle completion pulse
//   result       out  product low half or quotient
//   remainder    out  divide remainder (0 after a multiply)
//   div_by_zero  out  last completion was a divide with opB == 0
//   alu_A/alu_B  out  operands to the shared ALU
//   alu_sel      out  ALU function: 000 pass B, 010 add, 011 subtract
//   alu_out      in   combinational ALU result for the current cycle
//   alu_carry    in   ALU carry-out; on subtract, 1 means no borrow
module alu_muldiv_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [63:0] opA,
  input  logic [63:0] opB,
  output logic        busy,
  output logic        done,
  output logic [63:0] result,
  output logic [63:0] remainder,
  output logic        div_by_zero,
  output logic [63:0] alu_A,
  output logic [63:0] alu_B,
  output logic [2:0]  alu_sel,
  input  logic [63:0] alu_out,
  input  logic        alu_carry
);

  localparam logic [2:0] ALU_PASS_B = 3'b000;
  localparam logic [2:0] ALU_ADD    = 3'b010;
  localparam logic [2:0] ALU_SUB    = 3'b011;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t      r_state;
  logic [5:0]  r_cnt;
  // r_acc is P while multiplying and R while dividing; r_m is M or D.
  logic [63:0] r_acc;
  logic [63:0] r_q;
  logic [63:0] r_m;
  logic        r_op;
  logic        r_dbz;
  logic        r_busy;
  logic        r_done;
  logic [63:0] r_result;
  logic [63:0] r_remainder;
  logic        r_div_by_zero;

  // Divide step: shift the next dividend bit into the partial remainder.
  // When R[63] is set the shifted value has an implicit bit 64, so it is
  // always >= D and the subtract is taken regardless of the ALU borrow.
  logic [63:0] w_shift;
  logic        w_take;
  assign w_shift = {r_acc[62:0], r_q[63]};
  assign w_take  = r_acc[63] | alu_carry;

  // The ALU is combinational outside this block, so its operands must be a
  // same-cycle function of the current state.
  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    alu_A   = '0;
    alu_B   = '0;
    alu_sel = ALU_PASS_B;
    case (r_state)
      S_MUL: begin
        alu_A   = r_acc;
        alu_B   = r_q[0] ? r_m : '0;
        alu_sel = ALU_ADD;
      end
      S_DIV: begin
        alu_A   = w_shift;
        alu_B   = r_m;
        alu_sel = ALU_SUB;
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values and the simulation order of statements is moot.
  // NOTE: the datapath registers are plain flops (no RAM), so they are all
  // cleared by reset; a mid-operation reset simply abandons the operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_acc         <= '0;
      r_q           <= '0;
      r_m           <= '0;
      r_op          <= 1'b0;
      r_dbz         <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_result      <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_busy <= 1'b1;
            r_cnt  <= '0;
            r_op   <= op;
            if (op && (opB == '0)) begin
              // Divide by zero: stage the fixed outcome and finish at once.
              r_acc   <= opA;
              r_q     <= '0;
              r_m     <= '0;
              r_dbz   <= 1'b1;
              r_state <= S_DONE;
            end else if (op) begin
              r_acc   <= '0;
              r_q     <= opA;
              r_m     <= opB;
              r_dbz   <= 1'b0;
              r_state <= S_DIV;
            end else begin
              r_acc   <= '0;
              r_m     <= opA;
              r_q     <= opB;
              r_dbz   <= 1'b0;
              r_state <= S_MUL;
            end
          end
        end
        S_MUL: begin
          r_acc <= alu_out;
          r_m   <= r_m << 1;
          r_q   <= r_q >> 1;
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == 6'd63) r_state <= S_DONE;
        end
        S_DIV: begin
          r_acc <= w_take ? alu_out : w_shift;
          r_q   <= {r_q[62:0], w_take};
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == 6'd63) r_state <= S_DONE;
        end
        S_DONE: begin
          // For a divide Q holds the quotient and R the remainder; for a
          // multiply P is the product. A zero divisor staged R=opA, Q=0.
          r_done        <= 1'b1;
          r_busy        <= 1'b0;
          r_result      <= r_op ? r_q : r_acc;
          r_remainder   <= r_op ? r_acc : '0;
          r_div_by_zero <= r_dbz;
          r_state       <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign result      = r_result;
  assign remainder   = r_remainder;
  assign div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq. The shared ALU is modelled here as
// plain 65-bit arithmetic; expected results come from native *, / and %.
module tb_alu_muldiv_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic        op;
  logic [63:0] opA;
  logic [63:0] opB;
  logic        busy;
  logic        done;
  logic [63:0] result;
  logic [63:0] remainder;
  logic        div_by_zero;
  logic [63:0] alu_A;
  logic [63:0] alu_B;
  logic [2:0]  alu_sel;
  logic [63:0] alu_out;
  logic        alu_carry;
  logic [64:0] w_alu;

  int checks   = 0;
  int failures = 0;

  alu_muldiv_seq dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .opA         (opA),
    .opB         (opB),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .alu_A       (alu_A),
    .alu_B       (alu_B),
    .alu_sel     (alu_sel),
    .alu_out     (alu_out),
    .alu_carry   (alu_carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU: subtract is A + ~B + 1, so carry-out is 1 exactly when A >= B.
  always_comb begin
    w_alu = '0;
    case (alu_sel)
      3'b000:  w_alu = {1'b0, alu_B};
      3'b010:  w_alu = {1'b0, alu_A} + {1'b0, alu_B};
      3'b011:  w_alu = {1'b0, alu_A} + {1'b0, ~alu_B} + 65'd1;
      default: w_alu = '0;
    endcase
  end
  assign alu_out   = w_alu[63:0];
  assign alu_carry = w_alu[64];

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // Reference: outcome and start-edge-to-done latency of one operation.
  function automatic void ref_model(input logic o, input logic [63:0] a, input logic [63:0] b,
                                    output logic [63:0] r, output logic [63:0] rm,
                                    output logic z, output int lat);
    if (o && b == 64'd0) begin
      r = 64'd0; rm = a; z = 1'b1; lat = 1;
    end else if (o) begin
      r = a / b; rm = a % b; z = 1'b0; lat = 65;
    end else begin
      r = a * b; rm = 64'd0; z = 1'b0; lat = 65;
    end
  endfunction

  // Issues one start pulse, scrambles the operand inputs while busy, and
  // returns the number of edges after the start edge until done is seen.
  task automatic do_op(input logic o, input logic [63:0] a, input logic [63:0] b,
                       output int lat, output bit alu_act, output bit busy_bad);
    @(negedge clk);
    start = 1'b1; op = o; opA = a; opB = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; op = 1'($urandom_range(0, 1)); opA = rand64(); opB = rand64();
    lat = 0; alu_act = 1'b0; busy_bad = 1'b0;
    while (done !== 1'b1 && lat < 200) begin
      if (alu_sel !== 3'b000 || alu_A !== 64'd0 || alu_B !== 64'd0) alu_act = 1'b1;
      if (busy !== 1'b1) busy_bad = 1'b1;
      @(posedge clk);
      lat++;
      @(negedge clk);
      opA = rand64(); opB = rand64();
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b1; op = 1'b0; opA = rand64(); opB = rand64();
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, div_by_zero} !== 3'b000) begin
      failures++; $display("FAIL reset_flags: got %b expected 000", {busy, done, div_by_zero});
    end
    checks++;
    if (result !== 64'd0 || remainder !== 64'd0) begin
      failures++; $display("FAIL reset_results: got %h/%h expected 0/0", result, remainder);
    end
    checks++;
    if (alu_A !== 64'd0 || alu_B !== 64'd0 || alu_sel !== 3'b000) begin
      failures++; $display("FAIL reset_alu: got %h/%h/%b expected 0/0/000", alu_A, alu_B, alu_sel);
    end
    start = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL idle_after_reset: busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_mul_directed;
    int lat; bit act; bit bb;
    do_op(1'b0, 64'h1234_5678, 64'h10, lat, act, bb);
    checks++;
    if (lat !== 65) begin failures++; $display("FAIL mul_latency: got %0d expected 65", lat); end
    checks++;
    if (result !== 64'h1_2345_6780) begin
      failures++; $display("FAIL mul_result: got %h expected 123456780", result);
    end
    checks++;
    if (remainder !== 64'd0 || div_by_zero !== 1'b0) begin
      failures++; $display("FAIL mul_rem_dbz: got %h/%b expected 0/0", remainder, div_by_zero);
    end
    checks++;
    if (act !== 1'b1 || bb !== 1'b0) begin
      failures++; $display("FAIL mul_activity: alu_act=%b busy_gap=%b expected 1 0", act, bb);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL mul_done_width: done=%b expected 0", done); end
    checks++;
    if (alu_sel !== 3'b000 || alu_A !== 64'd0) begin
      failures++; $display("FAIL idle_alu: got %b/%h expected 000/0", alu_sel, alu_A);
    end
  endtask

  task automatic test_mul_overflow;
    int lat; bit act; bit bb;
    do_op(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, lat, act, bb);
    checks++;
    if (result !== 64'd1 || lat !== 65) begin
      failures++; $display("FAIL mul_overflow: got %h lat %0d expected 1 lat 65", result, lat);
    end
  endtask

  task automatic test_div_by_zero;
    int lat; bit act; bit bb;
    do_op(1'b1, 64'd55, 64'd0, lat, act, bb);
    checks++;
    if (lat !== 1) begin failures++; $display("FAIL dbz_latency: got %0d expected 1", lat); end
    checks++;
    if (result !== 64'd0 || remainder !== 64'd55 || div_by_zero !== 1'b1) begin
      failures++;
      $display("FAIL dbz_outputs: got %h/%h/%b expected 0/37/1", result, remainder, div_by_zero);
    end
    checks++;
    if (act !== 1'b0) begin failures++; $display("FAIL dbz_alu_activity: got %b expected 0", act); end
    repeat (5) @(negedge clk);
    checks++;
    if (result !== 64'd0 || remainder !== 64'd55 || div_by_zero !== 1'b1) begin
      failures++;
      $display("FAIL dbz_hold: got %h/%h/%b expected 0/37/1", result, remainder, div_by_zero);
    end
  endtask

  task automatic test_div_directed;
    int lat; bit act; bit bb;
    do_op(1'b1, 64'd100, 64'd7, lat, act, bb);
    checks++;
    if (result !== 64'd14 || remainder !== 64'd2 || div_by_zero !== 1'b0 || lat !== 65) begin
      failures++;
      $display("FAIL div_100_7: got %0d r%0d z%b lat %0d expected 14 r2 z0 lat 65",
               result, remainder, div_by_zero, lat);
    end
    do_op(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, lat, act, bb);
    checks++;
    if (result !== 64'd1 || remainder !== 64'h7FFF_FFFF_FFFF_FFFE) begin
      failures++;
      $display("FAIL div_r63: got %h r%h expected 1 r7ffffffffffffffe", result, remainder);
    end
  endtask

  task automatic test_random;
    int lat; int exp_lat; bit act; bit bb;
    logic o; logic [63:0] a; logic [63:0] b;
    logic [63:0] er; logic [63:0] erm; logic ez;
    for (int i = 0; i < 24; i++) begin
      o = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 1000)) : rand64();
      case ($urandom_range(0, 5))
        0:       b = 64'd0;
        1:       b = 64'($urandom_range(1, 20));
        2:       b = 64'($urandom);
        default: b = rand64();
      endcase
      ref_model(o, a, b, er, erm, ez, exp_lat);
      do_op(o, a, b, lat, act, bb);
      checks++;
      if (result !== er || remainder !== erm || div_by_zero !== ez || lat !== exp_lat) begin
        failures++;
        $display("FAIL rand_%0d op%b %h,%h: got %h r%h z%b lat %0d expected %h r%h z%b lat %0d",
                 i, o, a, b, result, remainder, div_by_zero, lat, er, erm, ez, exp_lat);
      end
    end
  endtask

  // Start held high: one operation per 66 cycles, operands sampled only at
  // the edge where the engine is idle.
  task automatic test_back_to_back;
    int cyc; int last; int n_done; int gap;
    logic [63:0] er; logic [63:0] erm; logic ez; int el;
    @(negedge clk);
    start = 1'b1; op = 1'($urandom_range(0, 1)); opA = rand64(); opB = rand64() | 64'd1;
    ref_model(op, opA, opB, er, erm, ez, el);
    cyc = 0; last = 1; n_done = 0;
    while (n_done < 3 && cyc < 400) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (done === 1'b1) begin
        n_done++;
        gap = cyc - last;
        last = cyc;
        checks++;
        if (result !== er || remainder !== erm) begin
          failures++;
          $display("FAIL b2b_result_%0d: got %h r%h expected %h r%h", n_done, result, remainder, er, erm);
        end
        checks++;
        if (gap !== ((n_done == 1) ? 65 : 66)) begin
          failures++;
          $display("FAIL b2b_spacing_%0d: got %0d expected %0d", n_done, gap, (n_done == 1) ? 65 : 66);
        end
        if (n_done < 3) begin
          op = 1'($urandom_range(0, 1)); opA = rand64(); opB = rand64() | 64'd1;
          ref_model(op, opA, opB, er, erm, ez, el);
        end else begin
          start = 1'b0;
        end
      end else begin
        op = 1'($urandom_range(0, 1)); opA = rand64(); opB = rand64();
      end
    end
    checks++;
    if (n_done !== 3) begin failures++; $display("FAIL b2b_timeout: got %0d dones expected 3", n_done); end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL b2b_idle: busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_reset_mid_op;
    int lat; bit act; bit bb; bit saw_done;
    @(negedge clk);
    start = 1'b1; op = 1'b0; opA = rand64(); opB = rand64();
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 64'd0) begin
      failures++;
      $display("FAIL midreset_clear: busy=%b done=%b result=%h expected 0 0 0", busy, done, result);
    end
    @(negedge clk);
    reset = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin failures++; $display("FAIL midreset_quiet: got activity expected none"); end
    do_op(1'b0, 64'd3, 64'd5, lat, act, bb);
    checks++;
    if (result !== 64'd15 || lat !== 65) begin
      failures++; $display("FAIL midreset_next_mul: got %0d lat %0d expected 15 lat 65", result, lat);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_mul_directed();
    test_mul_overflow();
    test_div_by_zero();
    test_div_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
